instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Parametrised instruction-fetch front end for the MIPS-basic core; replaces the bench-driven Instr register.
- Holds a PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers fetched words in a DEPTH-entry queue and presents them to decode (controller + datapath) with valid/ready.
- Supports redirect (flush plus new PC) and stops fetching on a HALT opcode.

Parameters:
- XLEN, 32, instruction width; opcode is always bits [XLEN-1 : XLEN-6].
- ADDR_W, 8, PC / imem address width (word address).
- DEPTH, 4, queue entries; power of two, >= 2.
- RESET_PC, 0, PC value after reset.
- HALT_OP, 6'b111111, opcode that stops fetching.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  fetch enable; when 0 no new request is issued.
- imem_req  output  1  read request; held until ack.
- imem_addr  output  ADDR_W  word address; stable while imem_req=1.
- imem_ack  input  1  read complete; imem_rdata valid this cycle.
- imem_rdata  input  XLEN  fetched word.
- redirect_valid  input  1  flush and restart at redirect_pc.
- redirect_pc  input  ADDR_W  new fetch address.
- instr_valid  output  1  queue head is valid.
- instr  output  XLEN  queue head word.
- instr_pc  output  ADDR_W  address of the head word.
- instr_ready  input  1  consumer accepts head when instr_valid=1.
- halted  output  1  HALT seen and queue fully drained.

Behaviour:
- Reset (async, asserted): pc=RESET_PC; queue empty; state S_RUN; imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, halted=0. imem_req drops immediately, not at the next edge.
- States:
  - S_RUN: fetching.
  - S_WAIT: one request outstanding.
  - S_HALT: fetch stopped.
- S_RUN -> S_WAIT: when en=1 and count+pending < DEPTH.
  - Assert imem_req with imem_addr=pc at that edge.
  - At most one request outstanding.
- S_WAIT, on imem_ack:
  - Deassert imem_req next cycle.
  - If drop=0: push {imem_rdata, imem_addr}; pc <= pc+1, mod 2^ADDR_W so 2^ADDR_W-1 wraps to 0.
  - If the pushed opcode == HALT_OP: go to S_HALT. The HALT word is still queued.
  - Otherwise return to S_RUN.
  - Back-to-back: a new request may issue the cycle after ack.
- Queue accounting: space is reserved at request time, so an ack never arrives with the queue full.
- Pop: on instr_valid && instr_ready. Push and pop in the same cycle leave count unchanged.
- Head outputs are registered/fifo-read: head data visible the cycle after the push into an empty queue (1-cycle fetch-to-decode latency after ack).
- Redirect (highest priority):
  - Queue flushed, pc <= redirect_pc, halted cleared, state -> S_RUN (or S_WAIT with drop=1 if a request is outstanding).
  - imem_req/imem_addr stay stable until the ack; the returned word is discarded and drop clears.
  - Any push or pop in the redirect cycle is ignored.
- en=0 blocks new requests only; an outstanding request completes normally.
- halted=1 while state==S_HALT and count==0. Only redirect or reset leaves S_HALT.
- imem_ack while imem_req=0 is ignored.

Optional Feature:
- Macro FETCH_STATS_EN.
- When defined, add two outputs:
  - stat_fetched (32b): counts accepted pushes.
  - stat_stall (32b): counts cycles with instr_ready=1 && instr_valid=0.
  - Both reset to 0, saturate at all-ones, and are not cleared by redirect.
- When undefined, neither port nor counter logic exists.

Decomposition:
- Shared package:
  - Opcode constants ADD, ADDI, SUB, SUBI, INC, DEC, AND, OR, XOR, NOT, SHIFT_LEFT, SHIFT_RIGHT, LW, SW, COMPARE, HALT.
  - Fetch state encoding S_RUN/S_WAIT/S_HALT.
- One sub-module: sync_fifo, parametrised width (XLEN+ADDR_W) and DEPTH, with push/pop/flush, count, and async reset.

Test Plan:
1. Reset release, en=1, ack 1 cycle after each req, imem[0..3]={LW,LW,ADD,SUB} words, instr_ready=1 -> imem_addr 0,1,2,3; instr/instr_pc pairs emerged in order, no duplicates.
2. instr_ready=0, DEPTH=4 -> exactly 4 requests issued then imem_req stays 0; raising ready -> pop one, one new request follows.
3. Redirect to 0x40 while a req to 0x05 is outstanding, ack 3 cycles later -> word from 0x05 dropped, queue empty, next req addr 0x40.
4. imem[2] opcode=HALT_OP -> no req after addr 2; halted=1 once the 3rd word is popped; redirect_pc=0x10 clears halted and fetch resumes at 0x10.
5. RESET_PC=8'hFE, ADDR_W=8 -> addresses FE, FF, 00, 01.
6. Assert rst mid-request (imem_req=1) -> imem_req, instr_valid low asynchronously; after release fetch restarts at RESET_PC. With FETCH_STATS_EN, stat_fetched=0.

Source files
------------

// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch front end.
//
// Contents:
//   - MIPS-basic opcode constants (6-bit major opcode, top bits of the word)
//   - fetch_state_t : fetch sequencer states
//   - OPCODE_W      : width of the opcode field
package instr_fetch_queue_pkg;

  localparam int OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_ADD         = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_ADDI        = 6'h01;
  localparam logic [OPCODE_W-1:0] OP_SUB         = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_SUBI        = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_INC         = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_DEC         = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_AND         = 6'h06;
  localparam logic [OPCODE_W-1:0] OP_OR          = 6'h07;
  localparam logic [OPCODE_W-1:0] OP_XOR         = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_NOT         = 6'h09;
  localparam logic [OPCODE_W-1:0] OP_SHIFT_LEFT  = 6'h0A;
  localparam logic [OPCODE_W-1:0] OP_SHIFT_RIGHT = 6'h0B;
  localparam logic [OPCODE_W-1:0] OP_LW          = 6'h0C;
  localparam logic [OPCODE_W-1:0] OP_SW          = 6'h0D;
  localparam logic [OPCODE_W-1:0] OP_COMPARE     = 6'h0E;
  localparam logic [OPCODE_W-1:0] OP_HALT        = 6'h3F;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_queue_sync_fifo.sv
// Synchronous FIFO used as the fetch queue.
//
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   push      : write wdata (ignored when full or flushing)
//   pop       : drop the head entry (ignored when empty or flushing)
//   flush     : empty the queue; wins over push and pop
//   wdata     : entry to write
//   rdata     : head entry (meaningless while empty)
//   empty     : no entries held
//   count     : number of entries held (0..DEPTH)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (count != FULL_CNT) && !flush;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: keeps a PC, reads words from instruction
// memory over a req/ack handshake, buffers them in a DEPTH-entry queue and
// hands them to decode with valid/ready. Supports redirect (flush + new PC)
// and stops fetching once a HALT opcode has been fetched.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   en              : allow new memory requests
//   imem_req/addr   : memory read request and word address (held until ack)
//   imem_ack/rdata  : read completion and returned word
//   redirect_valid  : flush queue and restart at redirect_pc
//   instr_valid     : queue head valid
//   instr/instr_pc  : head word and its address
//   instr_ready     : decode accepts the head
//   halted          : HALT fetched and queue drained
//   stat_fetched    : (FETCH_STATS_EN only) accepted pushes, saturating
//   stat_stall      : (FETCH_STATS_EN only) ready-but-empty cycles, saturating
//
// Build option: define FETCH_STATS_EN to add the statistics counters.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int                  XLEN     = 32,
  parameter int                  ADDR_W   = 8,
  parameter int                  DEPTH    = 4,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter logic [OPCODE_W-1:0] HALT_OP  = OP_HALT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [XLEN-1:0]   imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [XLEN-1:0]   instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              halted
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_stall
`endif
);

  localparam int EW = XLEN + ADDR_W;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              drop_q, drop_d;
  logic              push;
  logic              pop;
  logic [EW-1:0]     head;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({imem_rdata, imem_addr}),
    .rdata (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign imem_req    = (state_q == S_WAIT);
  assign imem_addr   = addr_q;
  assign instr_valid = !fifo_empty;
  assign instr       = instr_valid ? head[EW-1 -: XLEN] : '0;
  assign instr_pc    = instr_valid ? head[ADDR_W-1:0] : '0;
  assign pop         = instr_valid && instr_ready;
  assign halted      = (state_q == S_HALT) && fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
    end
  end

  // Only one request is ever in flight and a request is only issued from
  // S_RUN, so the queue space check needs only the current count. A request
  // still outstanding at redirect keeps the bus stable and its word is
  // discarded through drop.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    drop_d  = drop_q;
    push    = 1'b0;
    if (redirect_valid) begin
      pc_d = redirect_pc;
      if (state_q == S_WAIT && !imem_ack) begin
        state_d = S_WAIT;
        drop_d  = 1'b1;
      end else begin
        state_d = S_RUN;
        drop_d  = 1'b0;
      end
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (en && fifo_count < DEPTH_C) begin
            state_d = S_WAIT;
            addr_d  = pc_q;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            drop_d = 1'b0;
            if (drop_q) begin
              state_d = S_RUN;
            end else begin
              push    = 1'b1;
              pc_d    = pc_q + ADDR_W'(1);
              state_d = (imem_rdata[XLEN-1 -: OPCODE_W] == HALT_OP) ? S_HALT : S_RUN;
            end
          end
        end
        S_HALT: state_d = S_HALT;
        default: state_d = S_RUN;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  // push is already suppressed in redirect cycles, so it marks accepted words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_fetched <= '0;
      stat_stall   <= '0;
    end else begin
      if (push && stat_fetched != '1) begin
        stat_fetched <= stat_fetched + 32'd1;
      end
      if (instr_ready && !instr_valid && stat_stall != '1) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised bench for instr_fetch_queue with a memory responder and a
// reference model of the delivered instruction stream: after reset or a
// redirect to P, decode must see imem[P], imem[P+1], ... in order, stopping
// after a HALT word, with halted raised once that word has been consumed.
module tb_instr_fetch_queue;
  import instr_fetch_queue_pkg::*;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam logic [7:0] RESET_PC = 8'hFE;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_ready;
  logic        halted;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_stall;
`endif

  instr_fetch_queue #(
    .XLEN     (XLEN),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC),
    .HALT_OP  (OP_HALT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .halted         (halted)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_stall     (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] imem [256];
  int compared   = 0;
  int mismatched = 0;

  logic [7:0] expPc;
  bit         haltPopped;
  bit         reqActive;
  logic [7:0] reqAddr;
  int         reqWait;
  bit         ackedLast;
  bit         discardNext;
  int         fetchedCnt;
  int         stallCnt;
  int         pops;
  int         latMin;
  int         latMax;
  bit         autoRedirect;
  bit         armed;
  logic [7:0] armAddr;
  logic [7:0] armTarget;
  logic [7:0] reqLog [$];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic fillMem(input int haltPct);
    for (int a = 0; a < 256; a++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 99) < haltPct) ? OP_HALT : 6'($urandom_range(0, 14));
      imem[a] = {op, 26'($urandom)};
    end
  endtask

  task automatic resetModel();
    expPc       = RESET_PC;
    haltPopped  = 0;
    reqActive   = 0;
    reqWait     = 0;
    ackedLast   = 0;
    discardNext = 0;
    fetchedCnt  = 0;
    stallCnt    = 0;
    armed       = 0;
    reqLog.delete();
  endtask

  task automatic checkResetState();
    checkOutput("rst_req", imem_req, 0);
    checkOutput("rst_addr", imem_addr, RESET_PC);
    checkOutput("rst_valid", instr_valid, 0);
    checkOutput("rst_instr", instr, 0);
    checkOutput("rst_instr_pc", instr_pc, 0);
    checkOutput("rst_halted", halted, 0);
`ifdef FETCH_STATS_EN
    checkOutput("rst_stat_fetched", stat_fetched, 0);
    checkOutput("rst_stat_stall", stat_stall, 0);
`endif
  endtask

  // One cycle, called just after a falling edge: check what the DUT shows now,
  // then pick the inputs for the coming rising edge and advance the model.
  task automatic stepCycle(input int readyPct, input int redirPct, input int enPct, input int forcePc);
    bit         doRedir;
    bit         doAck;
    logic [7:0] target;

    checkOutput("halted", halted, haltPopped);
    if (haltPopped) begin
      checkOutput("halt_no_req", imem_req, 0);
      checkOutput("halt_empty", instr_valid, 0);
    end
    if (ackedLast) checkOutput("req_drop_after_ack", imem_req, 0);
    ackedLast = 0;
`ifdef FETCH_STATS_EN
    checkOutput("stat_fetched", stat_fetched, fetchedCnt);
    checkOutput("stat_stall", stat_stall, stallCnt);
`endif
    if (imem_req) begin
      if (reqActive) begin
        checkOutput("addr_stable", imem_addr, reqAddr);
      end else begin
        reqActive = 1;
        reqAddr   = imem_addr;
        reqWait   = 0;
        reqLog.push_back(imem_addr);
      end
    end

    doRedir = (forcePc >= 0) || ($urandom_range(0, 99) < redirPct) ||
              (autoRedirect && haltPopped && $urandom_range(0, 3) == 0);
    target  = (forcePc >= 0) ? 8'(forcePc) : 8'($urandom);
    if (armed && reqActive && reqAddr == armAddr) begin
      doRedir = 1;
      target  = armTarget;
      armed   = 0;
    end
    instr_ready = ($urandom_range(0, 99) < readyPct);
    en          = ($urandom_range(0, 99) < enPct);
    doAck = 0;
    if (reqActive) doAck = (reqWait >= latMin) && ((reqWait >= latMax) || $urandom_range(0, 1) == 1);
    if (doAck) begin
      imem_ack   = 1;
      imem_rdata = imem[reqAddr];
    end else if (!imem_req && $urandom_range(0, 9) == 0) begin
      imem_ack   = 1;
      imem_rdata = $urandom;
    end else begin
      imem_ack   = 0;
      imem_rdata = $urandom;
    end
    redirect_valid = doRedir;
    redirect_pc    = doRedir ? target : 8'($urandom);

    if (instr_ready && !instr_valid) stallCnt++;
    if (doAck) begin
      if (!doRedir && !discardNext) fetchedCnt++;
      discardNext = 0;
      reqActive   = 0;
      ackedLast   = 1;
    end else if (reqActive) begin
      reqWait++;
    end
    if (doRedir) begin
      discardNext = reqActive;
      expPc       = target;
      haltPopped  = 0;
    end else if (instr_valid && instr_ready) begin
      checkOutput("pop_pc", instr_pc, expPc);
      checkOutput("pop_instr", instr, imem[expPc]);
      if (imem[expPc][31:26] == OP_HALT) haltPopped = 1;
      expPc++;
      pops++;
    end
  endtask

  task automatic applyStimulus(input int cycles, input int readyPct, input int redirPct, input int enPct);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      stepCycle(readyPct, redirPct, enPct, -1);
    end
  endtask

  task automatic forceRedirect(input int pc, input int readyPct);
    @(negedge clk);
    stepCycle(readyPct, 0, 100, pc);
    reqLog.delete();
  endtask

  // Directed scenarios first, then a long randomised run.
  initial begin
    logic [7:0] a;
    rst = 1; en = 0; imem_ack = 0; imem_rdata = 0;
    redirect_valid = 0; redirect_pc = 0; instr_ready = 0;
    latMin = 0; latMax = 0; autoRedirect = 0; pops = 0;
    fillMem(0);
    imem[8'hFE] = {OP_LW,  26'h0000101};
    imem[8'hFF] = {OP_LW,  26'h0000202};
    imem[8'h00] = {OP_ADD, 26'h0000303};
    imem[8'h01] = {OP_SUB, 26'h0000404};
    resetModel();
    @(negedge clk);
    @(negedge clk);
    checkResetState();
    rst = 0;

    $display("[TB] in-order fetch from RESET_PC with address wrap");
    applyStimulus(20, 100, 0, 100);
    checkOutput("seq_len_ok", reqLog.size() >= 4, 1);
    if (reqLog.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        a = RESET_PC + 8'(i);
        checkOutput($sformatf("seq_addr%0d", i), reqLog[i], a);
      end
    end

    $display("[TB] queue fills with decode stalled");
    latMin = 1; latMax = 1;
    forceRedirect(8'h20, 0);
    applyStimulus(30, 0, 0, 100);
    checkOutput("full_req_count", reqLog.size(), 4);
    if (reqLog.size() == 4) checkOutput("full_last_addr", reqLog[3], 8'h23);
    checkOutput("full_req_idle", imem_req, 0);
    reqLog.delete();
    applyStimulus(1, 100, 0, 100);
    applyStimulus(15, 0, 0, 100);
    checkOutput("refill_req_count", reqLog.size(), 1);
    if (reqLog.size() == 1) checkOutput("refill_addr", reqLog[0], 8'h24);

    $display("[TB] redirect while a request is outstanding");
    latMin = 3; latMax = 3;
    armAddr = 8'h05; armTarget = 8'h40;
    forceRedirect(8'h05, 0);
    armed = 1;
    for (int i = 0; i < 12 && armed; i++) begin
      @(negedge clk);
      stepCycle(0, 0, 100, -1);
    end
    checkOutput("arm_timeout", armed, 0);
    applyStimulus(4, 0, 0, 100);
    checkOutput("redirect_flushed", instr_valid, 0);
    applyStimulus(20, 100, 0, 100);
    checkOutput("redirect_log_ok", reqLog.size() >= 2, 1);
    if (reqLog.size() >= 2) begin
      checkOutput("redirect_old_addr", reqLog[0], 8'h05);
      checkOutput("redirect_new_addr", reqLog[1], 8'h40);
    end

    $display("[TB] HALT stops fetch and redirect resumes");
    latMin = 0; latMax = 2;
    imem[8'h32] = {OP_HALT, 26'h0000505};
    forceRedirect(8'h30, 100);
    applyStimulus(30, 100, 0, 100);
    checkOutput("halt_req_count", reqLog.size(), 3);
    if (reqLog.size() == 3) checkOutput("halt_last_addr", reqLog[2], 8'h32);
    checkOutput("halt_raised", halted, 1);
    forceRedirect(8'h10, 100);
    applyStimulus(10, 100, 0, 100);
    checkOutput("halt_cleared", halted, 0);
    checkOutput("resume_log_ok", reqLog.size() >= 1, 1);
    if (reqLog.size() >= 1) checkOutput("resume_addr", reqLog[0], 8'h10);

    $display("[TB] asynchronous reset during a request");
    latMin = 2; latMax = 3;
    for (int i = 0; i < 20 && !reqActive; i++) begin
      @(negedge clk);
      stepCycle(100, 0, 100, -1);
    end
    checkOutput("mid_req_seen", reqActive, 1);
    imem_ack = 0; redirect_valid = 0; instr_ready = 0; en = 0;
    rst = 1;
    #1;
    checkResetState();
    @(negedge clk);
    rst = 0;
    resetModel();
    applyStimulus(10, 100, 0, 100);
    checkOutput("restart_log_ok", reqLog.size() >= 1, 1);
    if (reqLog.size() >= 1) checkOutput("restart_addr", reqLog[0], RESET_PC);

    $display("[TB] randomised traffic");
    latMin = 0; latMax = 3;
    fillMem(5);
    forceRedirect(8'h80, 70);
    autoRedirect = 1;
    applyStimulus(3000, 70, 2, 85);
    checkOutput("progress", pops > 200, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
